// File: rtl/generador_estimulos.sv
// -----------------------------------------------------------------------------
// generador_estimulos
//
// Stimulus generator for a downstream logic-gate stage. It produces the two
// operands A and B, either copied from two user switches (manual mode) or
// stepped automatically through 00,01,10,11 with a programmable dwell time per
// combination (automatic mode). The automatic sequence can be frozen with the
// pausa switch.
//
// Configuration macro:
//   GENERADOR_DEBOUNCE_EN  defined   -> sw_a/sw_b are debounced over DEB_CYCLES
//                          undefined -> sw_a/sw_b are used straight after the
//                                       synchronizer (default build)
//
// Parameters:
//   DWELL       clock cycles each combination is held in automatic mode
//   DEB_CYCLES  consecutive stable cycles needed to accept a switch change
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   modo    in   async switch, 0 = manual, 1 = automatic
//   pausa   in   async switch, 1 = freeze automatic sequence
//   sw_a    in   async user switch for A in manual mode
//   sw_b    in   async user switch for B in manual mode
//   A, B    out  registered operands
//   indice  out  registered current combination, always {A,B}
//   cambio  out  registered one-cycle pulse on every new {A,B} value
// -----------------------------------------------------------------------------
module generador_estimulos #(
  parameter int unsigned DWELL      = 32'd50000000,
  parameter int unsigned DEB_CYCLES = 32'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       modo,
  input  logic       pausa,
  input  logic       sw_a,
  input  logic       sw_b,
  output logic       A,
  output logic       B,
  output logic [1:0] indice,
  output logic       cambio
);

  typedef enum logic [1:0] {
    MANUAL     = 2'b00,
    AUTO_RUN   = 2'b01,
    AUTO_PAUSE = 2'b10
  } state_t;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL - 32'd1);

  // Reject parameter values outside the supported ranges at elaboration.
  if ((DWELL < 32'd2) || (DEB_CYCLES < 32'd2) || (DEB_CYCLES > 32'd16777215)) begin : g_bad_params
    $error("generador_estimulos: DWELL or DEB_CYCLES out of range");
  end

  // Synchronizer stages, bit order {modo, pausa, sw_a, sw_b}.
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;

  logic       modo_s;
  logic       pausa_s;
  logic [1:0] sw_sync_s;
  logic [1:0] sw_c_s;

  // Two-flop synchronizer for all asynchronous switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {modo, pausa, sw_a, sw_b};
      sync2_r <= sync1_r;
    end
  end

  assign modo_s    = sync2_r[3];
  assign pausa_s   = sync2_r[2];
  assign sw_sync_s = sync2_r[1:0];

`ifdef GENERADOR_DEBOUNCE_EN
  localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 32'd1);

  // One independent debouncer per user switch; index 1 is sw_a, 0 is sw_b.
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic        c_r;
    logic [23:0] cnt_r;

    // Count consecutive cycles the synchronized switch disagrees with the
    // accepted value; accept it on the DEB_CYCLES-th such cycle, restart on
    // any bounce back.
    always_ff @(posedge clk) begin
      if (rst) begin
        c_r   <= 1'b0;
        cnt_r <= 24'd0;
      end else if (sw_sync_s[g] != c_r) begin
        if (cnt_r == DEB_LAST) begin
          c_r   <= sw_sync_s[g];
          cnt_r <= 24'd0;
        end else begin
          c_r   <= c_r;
          cnt_r <= cnt_r + 24'd1;
        end
      end else begin
        c_r   <= c_r;
        cnt_r <= 24'd0;
      end
    end

    assign sw_c_s[g] = c_r;
  end
`else
  assign sw_c_s = sw_sync_s;
`endif

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  ab_r;
  logic [1:0]  ab_next_s;
  logic [31:0] dwell_r;
  logic [31:0] dwell_next_s;
  logic        cambio_r;

  // Next-state, next-operand and dwell-counter logic.
  always_comb begin
    state_next_s = state_r;
    ab_next_s    = ab_r;
    dwell_next_s = dwell_r;
    case (state_r)
      MANUAL: begin
        if (modo_s) begin
          // Any entry into automatic mode starts the sequence from 00.
          state_next_s = pausa_s ? AUTO_PAUSE : AUTO_RUN;
          ab_next_s    = 2'b00;
          dwell_next_s = 32'd0;
        end else begin
          state_next_s = MANUAL;
          ab_next_s    = sw_c_s;
          dwell_next_s = 32'd0;
        end
      end
      AUTO_RUN: begin
        if (!modo_s) begin
          state_next_s = MANUAL;
          ab_next_s    = sw_c_s;
          dwell_next_s = 32'd0;
        end else if (pausa_s) begin
          // Freeze: count and operands hold so a later resume continues.
          state_next_s = AUTO_PAUSE;
        end else if (dwell_r == DWELL_LAST) begin
          state_next_s = AUTO_RUN;
          dwell_next_s = 32'd0;
          ab_next_s    = ab_r + 2'd1;
        end else begin
          state_next_s = AUTO_RUN;
          dwell_next_s = dwell_r + 32'd1;
        end
      end
      AUTO_PAUSE: begin
        if (!modo_s) begin
          state_next_s = MANUAL;
          ab_next_s    = sw_c_s;
          dwell_next_s = 32'd0;
        end else if (!pausa_s) begin
          state_next_s = AUTO_RUN;
        end else begin
          state_next_s = AUTO_PAUSE;
        end
      end
      default: begin
        state_next_s = MANUAL;
        ab_next_s    = 2'b00;
        dwell_next_s = 32'd0;
      end
    endcase
  end

  // State, operand, dwell and change-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= MANUAL;
      ab_r     <= 2'b00;
      dwell_r  <= 32'd0;
      cambio_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      ab_r     <= ab_next_s;
      dwell_r  <= dwell_next_s;
      // Pulse in the same cycle the new value becomes visible.
      cambio_r <= (ab_next_s != ab_r);
    end
  end

  assign A      = ab_r[1];
  assign B      = ab_r[0];
  assign indice = ab_r;
  assign cambio = cambio_r;

endmodule

// File: tb/tb_generador_estimulos.sv
// -----------------------------------------------------------------------------
// tb_generador_estimulos
//
// Directed bench for generador_estimulos with DWELL=3, DEB_CYCLES=4. Stimulus
// pushes the expected {A,B} value and the cycle at which its cambio pulse must
// appear; a monitor pops and compares on every cambio pulse. Direct checks
// cover reset and hold conditions. Works in both builds of the design.
// -----------------------------------------------------------------------------
module tb_generador_estimulos;

  typedef struct packed {
    logic [1:0] val;
    int         cyc;
  } exp_t;

`ifdef GENERADOR_DEBOUNCE_EN
  localparam int LAT = 7;   // 2 sync + 4 debounce + 1 output register
`else
  localparam int LAT = 3;   // 2 sync + 1 output register
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       modo;
  logic       pausa;
  logic       sw_a;
  logic       sw_b;
  logic       A;
  logic       B;
  logic [1:0] indice;
  logic       cambio;

  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  generador_estimulos #(
    .DWELL      (3),
    .DEB_CYCLES (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .modo   (modo),
    .pausa  (pausa),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .A      (A),
    .B      (B),
    .indice (indice),
    .cambio (cambio)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp expected pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string name, input logic [1:0] ab_exp, input logic cambio_exp);
    tests++;
    if ({A, B} !== ab_exp || indice !== ab_exp || cambio !== cambio_exp) begin
      fails++;
      $display("FAIL %s: got A=%b B=%b indice=%b cambio=%b, required AB=%b indice=%b cambio=%b",
               name, A, B, indice, cambio, ab_exp, ab_exp, cambio_exp);
    end
  endtask

  // Scoreboard monitor: every cambio pulse must match the next expectation.
  always @(negedge clk) begin
    if (mon_en && cambio === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cambio: pulse at cycle %0d with indice=%b, required no pulse", cyc, indice);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (indice !== e.val || {A, B} !== e.val || cyc != e.cyc) begin
          fails++;
          $display("FAIL cambio_step: got indice=%b AB=%b at cycle %0d, required %b at cycle %0d",
                   indice, {A, B}, cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    int k;
    int j;

    // Reset held 3 cycles with every input high.
    rst = 1'b1; modo = 1'b1; pausa = 1'b1; sw_a = 1'b1; sw_b = 1'b1;
    tick(1);
    check_out("reset_c1", 2'b00, 1'b0);
    mon_en = 1'b1;
    tick(1);
    check_out("reset_c2", 2'b00, 1'b0);
    tick(1);
    check_out("reset_c3", 2'b00, 1'b0);
    rst = 1'b0; modo = 1'b0; pausa = 1'b0; sw_a = 1'b0; sw_b = 1'b0;
    tick(4);
    check_out("idle_manual", 2'b00, 1'b0);

`ifdef GENERADOR_DEBOUNCE_EN
    // sw_a bounces 1,0,1 with 2-cycle widths, then stays 1.
    sw_a = 1'b1; tick(2);
    sw_a = 1'b0; tick(2);
    sw_a = 1'b1;
    k = cyc;
    push(2'b10, k + 7);
    tick(10);
    check_out("deb_a_high", 2'b10, 1'b0);
    sw_a = 1'b0;
    k = cyc;
    push(2'b00, k + 7);
    tick(10);
    // Single-cycle glitch on sw_b must be filtered out entirely.
    sw_b = 1'b1; tick(1);
    sw_b = 1'b0; tick(8);
    check_out("deb_b_glitch", 2'b00, 1'b0);
`else
    // sw_b 0->1, back to 0, then a 1-cycle pulse that B follows.
    sw_b = 1'b1;
    k = cyc;
    push(2'b01, k + 3);
    tick(6);
    check_out("manual_b_high", 2'b01, 1'b0);
    sw_b = 1'b0;
    k = cyc;
    push(2'b00, k + 3);
    tick(6);
    sw_b = 1'b1;
    k = cyc;
    push(2'b01, k + 3);
    push(2'b00, k + 4);
    tick(1);
    sw_b = 1'b0;
    tick(6);
    check_out("manual_b_pulse", 2'b00, 1'b0);
`endif

    // Automatic run: steps every 3 cycles after the entry cycle, with wrap.
    modo = 1'b1; pausa = 1'b0;
    k = cyc;
    push(2'b01, k + 6);
    push(2'b10, k + 9);
    push(2'b11, k + 12);
    push(2'b00, k + 15);
    push(2'b01, k + 18);
    // Pause reaches the FSM at k+20, when the dwell count is 1.
    tick(17);
    pausa = 1'b1;
    tick(10);
    check_out("pause_hold", 2'b01, 1'b0);
    pausa = 1'b0;
    // Resume takes effect at k+30; two cycles later the next step.
    push(2'b10, k + 32);
    tick(6);
    check_out("resume_step", 2'b10, 1'b0);

    // Reset for one cycle mid-dwell at 10; mode dropped to stay manual.
    rst = 1'b1; modo = 1'b0;
    tick(1);
    check_out("rst_mid_dwell", 2'b00, 1'b0);
    rst = 1'b0;
    tick(1);
    check_out("after_rst", 2'b00, 1'b0);
    tick(5);

    // Auto entry from 11 loads 00; return to manual picks up switches.
    sw_a = 1'b1; sw_b = 1'b1;
    k = cyc;
    push(2'b11, k + LAT);
    tick(LAT + 3);
    modo = 1'b1;
    j = cyc;
    push(2'b00, j + 3);
    push(2'b01, j + 6);
    tick(4);
    modo = 1'b0;
    push(2'b11, j + 7);
    tick(6);
    check_out("back_to_manual", 2'b11, 1'b0);
    sw_a = 1'b0; sw_b = 1'b0;
    k = cyc;
    push(2'b00, k + LAT);
    tick(LAT + 4);
    check_out("final_manual", 2'b00, 1'b0);

    tick(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/generador_estimulos.md
GENERADOR_ESTIMULOS -- requirements
Module: generador_estimulos

Interface
REQ-001 Parameter DWELL, default 50000000, clock cycles each input combination is held in automatic mode (legal range 2..2^32-1).
REQ-002 Parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a switch change (legal range 2..2^24-1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single rising-edge clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 modo  input  1  asynchronous switch; 0 = manual, 1 = automatic.
REQ-007 pausa  input  1  asynchronous switch; 1 = freeze automatic sequence.
REQ-008 sw_a, sw_b  input  1 each  asynchronous user switches for manual mode.
REQ-009 A, B  output  1 each  registered operands driving the downstream logic-gate stage.
REQ-010 indice  output  2  registered current combination, always equal to {A,B}.
REQ-011 cambio  output  1  registered one-cycle pulse marking a new {A,B} value.

Function
REQ-012 modo, pausa, sw_a, sw_b SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 FSM states SHALL be MANUAL, AUTO_RUN, AUTO_PAUSE, evaluated on synchronized modo/pausa.
REQ-014 Transitions: MANUAL->AUTO_RUN when modo=1 and pausa=0; MANUAL->AUTO_PAUSE when modo=1 and pausa=1; AUTO_RUN<->AUTO_PAUSE follows pausa; either AUTO state->MANUAL when modo=0.
REQ-015 MANUAL: {A,B} SHALL equal the conditioned switch values {sw_a_c, sw_b_c}, registered once.
REQ-016 Entering AUTO_RUN or AUTO_PAUSE from MANUAL SHALL load {A,B}=00 and clear the dwell counter in that same transition cycle.
REQ-017 AUTO_RUN: dwell counter SHALL count 0..DWELL-1; in the cycle it equals DWELL-1 it SHALL return to 0 and {A,B} SHALL increment by 1 modulo 4 (11 wraps to 00).
REQ-018 AUTO_PAUSE: dwell counter and {A,B} SHALL hold; on return to AUTO_RUN counting resumes from the held count.
REQ-019 AUTO->MANUAL: {A,B} SHALL take the conditioned switch values in the transition cycle.
REQ-020 cambio SHALL be 1 for exactly the first clock cycle in which a {A,B} value differing from the previous cycle's value is visible, else 0; a transition producing an equal value SHALL NOT pulse.
REQ-021 Simultaneous switch change and mode change: mode transition rules take precedence; switch value is sampled as conditioned in that cycle.

Reset
REQ-022 While rst=1 at a clock edge: state=MANUAL, A=0, B=0, indice=00, cambio=0, dwell and debounce counters=0, synchronizer and conditioned values=0.
REQ-023 rst SHALL dominate all other inputs, including mid-dwell and mid-debounce; no cambio pulse is generated by reset itself.
REQ-024 After rst deasserts, the first state evaluation SHALL use synchronized inputs (2-cycle latency).

Configuration
REQ-025 Macro GENERADOR_DEBOUNCE_EN defined: sw_a_c/sw_b_c SHALL each update only after the synchronized switch differs from the current conditioned value for DEB_CYCLES consecutive cycles; any bounce back resets that bit's counter to 0; latency edge->A is 2+DEB_CYCLES+1 cycles.
REQ-026 Macro GENERADOR_DEBOUNCE_EN undefined: sw_a_c/sw_b_c SHALL equal the synchronized values, no debounce counters synthesized; latency edge->A is 3 cycles; modo/pausa are never debounced in either build.

Verification (bench overrides DWELL=3, DEB_CYCLES=4)
REQ-027 Reset held 3 cycles with all inputs 1 -> A=B=0, indice=00, cambio=0 throughout; state MANUAL.
REQ-028 modo=1, pausa=0 for 14 cycles -> {A,B} 00,01,10,11,00 each held 3 cycles, cambio one pulse per step, wrap 11->00 pulses.
REQ-029 In AUTO_RUN at dwell count 1, pausa=1 for 10 cycles then 0 -> {A,B} frozen, no cambio; next step exactly 2 cycles after resumption takes effect.
REQ-030 Debounce build, manual: sw_a toggles 1,0,1 with 2-cycle widths then held 1 -> A rises exactly 2+4+1 cycles after the final edge, single cambio.
REQ-031 Non-debounce build, manual: sw_b 0->1 -> B=1 three cycles later with cambio; sw_b pulse of 1 cycle -> B follows it for 1 cycle, two cambio pulses.
REQ-032 In AUTO_RUN at {A,B}=10, assert rst for 1 cycle mid-dwell -> next cycle A=B=0, counters 0, state MANUAL, no cambio.
